fft_out_reorder: RTL and testbench

Output reorder buffer for the 32-point SDF FFT pipeline. It sits after the last butterfly stage and accepts the 32 bins of each frame in the pipeline's bit-reversed arrival order. It emits each frame in natural bin order (0..31) as a back-to-back burst with a frame marker and bin index. Ping-pong storage lets frame N+1 be written while frame N is read.

---
 rtl/fft_out_reorder_if.sv | 52 +++++
 rtl/fft_out_reorder.sv | 178 +++++++++++++++++
 tb/tb_fft_out_reorder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fft_out_reorder_if.sv
// ---------------------------------------------------------------------------
// fft_out_reorder_if
//   Sample stream bundle around the FFT output reorder buffer.
//
//   Producer side (pipeline -> reorder buffer):
//     valid_i        one FFT output sample this cycle, bit-reversed order
//     data_in_r/i    real / imaginary part, signed, DW bits
//   Consumer side (reorder buffer -> downstream):
//     valid_o        one natural-order bin this cycle
//     frame_start_o  high with bin 0 of every output frame only
//     bin_idx_o      natural bin index 0..31 of the current sample
//     data_out_r/i   real / imaginary part, bit-exact copy of the input
//
//   Modports:
//     slave   the reorder buffer's view (takes inputs, drives outputs)
//     master  the environment's view (drives inputs, observes outputs)
// ---------------------------------------------------------------------------
interface fft_out_reorder_if #(
  parameter int DW = 16
);
  logic                 valid_i;
  logic signed [DW-1:0] data_in_r;
  logic signed [DW-1:0] data_in_i;

  logic                 valid_o;
  logic                 frame_start_o;
  logic        [4:0]    bin_idx_o;
  logic signed [DW-1:0] data_out_r;
  logic signed [DW-1:0] data_out_i;

  modport slave (
    input  valid_i,
    input  data_in_r,
    input  data_in_i,
    output valid_o,
    output frame_start_o,
    output bin_idx_o,
    output data_out_r,
    output data_out_i
  );

  modport master (
    output valid_i,
    output data_in_r,
    output data_in_i,
    input  valid_o,
    input  frame_start_o,
    input  bin_idx_o,
    input  data_out_r,
    input  data_out_i
  );
endinterface

// File: rtl/fft_out_reorder.sv
// ---------------------------------------------------------------------------
// fft_out_reorder
//   Output reorder buffer for a 32-point SDF FFT. Accepts each frame's 32
//   bins in bit-reversed arrival order and replays the frame in natural bin
//   order (0..31) as one gapless burst, tagged with bin index and a frame
//   marker. Two 32-entry banks ping-pong so frame N+1 can fill while frame N
//   drains. Samples pass through untouched.
//
//   Ports:
//     clk    system clock, rising-edge
//     rst_n  asynchronous active-low reset; discards partial input frames
//            and any unread burst
//     bus    fft_out_reorder_if.slave (valid_i, data_in_r/i in;
//            valid_o, frame_start_o, bin_idx_o, data_out_r/i out)
//
//   Pipeline:
//     p0  input register (valid + sample)
//     p1  bank write / read-side FSM and counters
//     p2  output register
//   Last sample of a frame sampled at edge N -> written and read launched at
//   N+1 -> bin 0 on the outputs after N+2, bin 31 after N+33.
// ---------------------------------------------------------------------------
module fft_out_reorder #(
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_out_reorder_if.slave   bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  // Arrival position -> natural bin address.
  function automatic logic [4:0] bitrev5(input logic [4:0] b);
    return {b[0], b[1], b[2], b[3], b[4]};
  endfunction

  // ------------------------------------------------------------------ p0 --
  logic                 vld_p0_q, vld_p0_d;
  logic signed [DW-1:0] in_r_p0_q, in_r_p0_d;
  logic signed [DW-1:0] in_i_p0_q, in_i_p0_d;

  always_comb begin
    vld_p0_d  = bus.valid_i;
    in_r_p0_d = bus.data_in_r;
    in_i_p0_d = bus.data_in_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
    end
  end

  always_ff @(posedge clk) begin
    in_r_p0_q <= in_r_p0_d;
    in_i_p0_q <= in_i_p0_d;
  end

  // ------------------------------------------------------------------ p1 --
  logic [2*DW-1:0] mem_q [0:1][0:31];

  logic       wr_bank_q, wr_bank_d;
  logic [4:0] wr_cnt_q,  wr_cnt_d;
  logic [4:0] wr_addr_p1;
  logic       launch_p1;

  state_t     state_q,   state_d;
  logic       rd_bank_q, rd_bank_d;
  logic [4:0] rd_cnt_q,  rd_cnt_d;
  logic [2*DW-1:0] rd_word_p1;

  // Write side: one entry per registered valid sample; gaps hold wr_cnt.
  // Completing a frame flips the bank and hands the full one to the reader.
  always_comb begin
    wr_addr_p1 = bitrev5(wr_cnt_q);
    launch_p1  = vld_p0_q && (wr_cnt_q == 5'd31);
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    if (vld_p0_q) begin
      wr_cnt_d = wr_cnt_q + 5'd1;
      if (launch_p1) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  // Storage is never reset; vld_p0_q is, so nothing is written under reset.
  always_ff @(posedge clk) begin
    if (vld_p0_q) begin
      mem_q[wr_bank_q][wr_addr_p1] <= {in_r_p0_q, in_i_p0_q};
    end
  end

  assign rd_word_p1 = mem_q[rd_bank_q][rd_cnt_q];

  // ------------------------------------------------------------------ p2 --
  logic                 vld_p2_q,   vld_p2_d;
  logic                 start_p2_q, start_p2_d;
  logic        [4:0]    bin_p2_q,   bin_p2_d;
  logic signed [DW-1:0] out_r_p2_q, out_r_p2_d;
  logic signed [DW-1:0] out_i_p2_q, out_i_p2_d;

  // Read FSM and output load. A launch on the same cycle as the bin-31 read
  // restarts the burst on the other bank, which keeps the output gapless
  // across back-to-back frames.
  always_comb begin
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    vld_p2_d   = 1'b0;
    start_p2_d = 1'b0;
    bin_p2_d   = bin_p2_q;
    out_r_p2_d = out_r_p2_q;
    out_i_p2_d = out_i_p2_q;

    case (state_q)
      ST_READ: begin
        vld_p2_d   = 1'b1;
        start_p2_d = (rd_cnt_q == 5'd0);
        bin_p2_d   = rd_cnt_q;
        out_r_p2_d = $signed(rd_word_p1[2*DW-1:DW]);
        out_i_p2_d = $signed(rd_word_p1[DW-1:0]);
        rd_cnt_d   = rd_cnt_q + 5'd1;
        if (rd_cnt_q == 5'd31) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch_p1) begin
      state_d   = ST_READ;
      rd_bank_d = wr_bank_q;
      rd_cnt_d  = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= 5'd0;
      state_q    <= ST_IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= 5'd0;
      vld_p2_q   <= 1'b0;
      start_p2_q <= 1'b0;
      bin_p2_q   <= 5'd0;
      out_r_p2_q <= '0;
      out_i_p2_q <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      vld_p2_q   <= vld_p2_d;
      start_p2_q <= start_p2_d;
      bin_p2_q   <= bin_p2_d;
      out_r_p2_q <= out_r_p2_d;
      out_i_p2_q <= out_i_p2_d;
    end
  end

  assign bus.valid_o       = vld_p2_q;
  assign bus.frame_start_o = start_p2_q;
  assign bus.bin_idx_o     = bin_p2_q;
  assign bus.data_out_r    = out_r_p2_q;
  assign bus.data_out_i    = out_i_p2_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_out_reorder
//   Directed sequence with random data for the FFT output reorder buffer.
//   The reference model collects accepted samples per frame and, on the
//   32nd, schedules the natural-order frame (bin k = arrival bitrev(k)) at
//   absolute clock edges N+2 .. N+33. Every edge all outputs are compared
//   against that schedule; between bursts data and bin index must hold.
// ---------------------------------------------------------------------------
module tb_fft_out_reorder;
  localparam int DW = 16;

  logic clk;
  logic rst_n;

  fft_out_reorder_if #(.DW(DW)) bus ();

  fft_out_reorder #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [31:0] frame_q [$];
  logic [31:0] exp_data [int];
  int          exp_bin  [int];
  logic [15:0] last_r, last_i;
  logic [4:0]  last_bin;

  function automatic int rev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic        ev;
    logic        es;
    logic [31:0] w;
    ev = exp_data.exists(edge_n);
    es = 1'b0;
    if (ev) begin
      w        = exp_data[edge_n];
      last_r   = w[31:16];
      last_i   = w[15:0];
      last_bin = 5'(exp_bin[edge_n]);
      es       = (exp_bin[edge_n] == 0);
    end
    chk("valid_o",       16'(bus.valid_o),       16'(ev));
    chk("frame_start_o", 16'(bus.frame_start_o), 16'(es));
    chk("bin_idx_o",     16'(bus.bin_idx_o),     16'(last_bin));
    chk("data_out_r",    bus.data_out_r,         last_r);
    chk("data_out_i",    bus.data_out_i,         last_i);
  endtask

  task automatic model_clear();
    exp_data.delete();
    exp_bin.delete();
    frame_q.delete();
    last_r   = '0;
    last_i   = '0;
    last_bin = '0;
  endtask

  // One clock: drive at negedge, accept at posedge, check 1 time unit later.
  task automatic tick(input logic v, input logic [15:0] r, input logic [15:0] i);
    @(negedge clk);
    bus.valid_i   = v;
    bus.data_in_r = r;
    bus.data_in_i = i;
    @(posedge clk);
    edge_n++;
    if (rst_n && v) begin
      frame_q.push_back({r, i});
      if (frame_q.size() == 32) begin
        for (int k = 0; k < 32; k++) begin
          exp_data[edge_n + 2 + k] = frame_q[rev5(k)];
          exp_bin[edge_n + 2 + k]  = k;
        end
        frame_q.delete();
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
  endtask

  initial begin
    logic [15:0] v16;
    logic [15:0] ext [4];
    ext[0] = 16'h8000;
    ext[1] = 16'h7FFF;
    ext[2] = 16'h8000;
    ext[3] = 16'h7FFF;
    model_clear();
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
    rst_n = 1'b1;
    #2;
    assert_reset();

    // Reset held with random valid traffic: outputs stay 0.
    for (int k = 0; k < 6; k++) tick(1'b1, 16'($urandom), 16'($urandom));
    rst_n = 1'b1;
    idle(3);

    // Single contiguous frame: r = c, i = -c.
    for (int c = 0; c < 32; c++) tick(1'b1, 16'(c), 16'(-c));
    idle(40);

    // Same frame, valid toggling 1,0,1,0.
    for (int c = 0; c < 32; c++) begin
      tick(1'b1, 16'(c), 16'(-c));
      tick(1'b0, 16'($urandom), 16'($urandom));
    end
    idle(40);

    // Three back-to-back frames, r = 100*f + c, random imag.
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 32; c++) tick(1'b1, 16'(100 * f + c), 16'($urandom));
    idle(40);

    // Extremes on both components, plus a random-gapped random frame.
    for (int c = 0; c < 32; c++) tick(1'b1, ext[c % 4], ext[(c + 1) % 4]);
    idle(36);
    for (int c = 0; c < 32; c++) begin
      if ($urandom_range(0, 2) == 0) tick(1'b0, 16'($urandom), 16'($urandom));
      v16 = 16'($urandom);
      tick(1'b1, v16, ~v16);
    end
    idle(40);

    // Mid-operation reset: frame 1 draining, frame 2 partially filled.
    for (int c = 0; c < 32; c++) tick(1'b1, 16'(16'h1000 + c), 16'($urandom));
    for (int c = 0; c < 17; c++) tick(1'b1, 16'(16'h2000 + c), 16'($urandom));
    assert_reset();
    for (int k = 0; k < 3; k++) tick(1'b1, 16'($urandom), 16'($urandom));
    rst_n = 1'b1;
    idle(2);
    for (int c = 0; c < 32; c++) tick(1'b1, 16'(16'h3000 + c), 16'($urandom));
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
